// File: rtl/sc_pkg.sv
// Shared definitions for the sequential-circuit library: width bounds,
// count direction encoding and an elaboration-time log2 helper.
package sc_pkg;

  localparam int SC_WIDTH_MIN = 2;
  localparam int SC_WIDTH_MAX = 16;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_e;

  // Bits needed to hold values 0..v-1; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/tff_mod_counter_tcell.sv
// Single toggle flip-flop: flips on every rising edge where t is high.
module tcell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)   q <= 1'b0;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter whose state bits are toggle cells driven by
// t = q ^ next; exposes combinational terminal count, wrap pulse and sticky ovf.
module tff_mod_counter
  import sc_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < SC_WIDTH_MIN || WIDTH > SC_WIDTH_MAX ||
      MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_param
    $error("tff_mod_counter: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d, t;
  logic             wrap_q, ovf_q;
  cnt_dir_e         dir;

  assign dir = cnt_dir_e'(up);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (din > MAXV) ? MAXV : din;
    end else if (en) begin
      // Out-of-range states (SEU only) recover to 0 without signalling a wrap.
      if (cnt_q > MAXV)            cnt_d = '0;
      else if (dir == DIR_UP)      cnt_d = (cnt_q == MAXV) ? '0 : cnt_q + 1'b1;
      else                         cnt_d = (cnt_q == '0) ? MAXV : cnt_q - 1'b1;
    end
  end

  assign t  = cnt_q ^ cnt_d;
  assign tc = en & ~load & (((dir == DIR_UP) & (cnt_q == MAXV)) |
                            ((dir == DIR_DOWN) & (cnt_q == '0)));

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    tcell u_tcell (
      .clk (clk),
      .rst (rst),
      .t   (t[gi]),
      .q   (cnt_q[gi])
    );
  end

  // A set on the same edge as a clear wins so no wrap is ever lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= tc;
      if (tc)           ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule
